// File: rtl/alu_exec.sv
// alu_exec: three-cycle execute stage (IDLE/EXEC/WB) around an external ALU.
// Optional sticky zero/carry flags are built when ALU_EXEC_FLAGS_EN is defined.
module alu_exec #(
   parameter int WORD_SIZE = 64,
   parameter int REG_COUNT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           in_op,
   input  logic [2:0]           in_rd,
   input  logic [2:0]           in_rs1,
   input  logic [2:0]           in_rs2,
   input  logic                 in_imm_sel,
   input  logic [WORD_SIZE-1:0] in_imm,
   output logic [WORD_SIZE-1:0] alu_d1,
   output logic [WORD_SIZE-1:0] alu_d2,
   output logic [3:0]           alu_op,
   input  logic [WORD_SIZE-1:0] alu_out,
   input  logic                 alu_iszero,
   input  logic                 alu_iscarry,
   output logic                 out_valid,
   output logic [WORD_SIZE-1:0] out_data,
   output logic                 out_zero,
   output logic                 out_carry,
   output logic [2:0]           out_rd,
   input  logic                 wr_en,
   input  logic [2:0]           wr_addr,
   input  logic [WORD_SIZE-1:0] wr_data,
   input  logic [2:0]           dbg_addr,
   output logic [WORD_SIZE-1:0] dbg_data,
   output logic                 flag_zero,
   output logic                 flag_carry
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      WB
   } state_t;

   state_t               state_q, state_d;
   logic                 accept;
   logic [WORD_SIZE-1:0] regs_q [REG_COUNT];
   logic [WORD_SIZE-1:0] d1_q, d2_q;
   logic [3:0]           op_q;
   logic [2:0]           rd_q;
   logic [WORD_SIZE-1:0] res_q;
   logic                 zero_q, carry_q;
   logic [2:0]           ord_q;
   logic [WORD_SIZE-1:0] rs1_val, rs2_val;

   // Register 0 and out-of-range addresses read as zero.
   function automatic logic [WORD_SIZE-1:0] read_reg(input logic [2:0] a);
      if (a == 3'd0 || int'(a) >= REG_COUNT) return '0;
      return regs_q[a];
   endfunction

   // Operand and debug read ports from current register contents.
   always_comb begin
      rs1_val  = read_reg(in_rs1);
      rs2_val  = read_reg(in_rs2);
      dbg_data = read_reg(dbg_addr);
   end

   // State register; reset aborts any in-flight instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: one cycle each in IDLE, EXEC and WB.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC:    state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == WB);

   // Operand latch at accept and result capture at the end of EXEC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d1_q    <= '0;
         d2_q    <= '0;
         op_q    <= '0;
         rd_q    <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ord_q   <= '0;
      end else begin
         if (accept) begin
            d1_q <= rs1_val;
            d2_q <= in_imm_sel ? in_imm : rs2_val;
            op_q <= in_op;
            rd_q <= in_rd;
         end
         if (state_q == EXEC) begin
            res_q   <= alu_out;
            zero_q  <= alu_iszero;
            carry_q <= alu_iscarry;
            ord_q   <= rd_q;
         end
      end
   end

   assign alu_d1    = d1_q;
   assign alu_d2    = d2_q;
   assign alu_op    = op_q;
   assign out_data  = res_q;
   assign out_zero  = zero_q;
   assign out_carry = carry_q;
   assign out_rd    = ord_q;

   // Register file: preload port first, writeback last so it wins a collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      end else begin
         if (wr_en && wr_addr != 3'd0 && int'(wr_addr) < REG_COUNT)
            regs_q[wr_addr] <= wr_data;
         if (state_q == WB && ord_q != 3'd0 && int'(ord_q) < REG_COUNT)
            regs_q[ord_q] <= res_q;
      end
   end

`ifdef ALU_EXEC_FLAGS_EN
   logic fz_q, fc_q;

   // Sticky flags follow the reported result at the end of WB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fz_q <= 1'b0;
         fc_q <= 1'b0;
      end else if (state_q == WB) begin
         fz_q <= zero_q;
         fc_q <= carry_q;
      end
   end

   assign flag_zero  = fz_q;
   assign flag_carry = fc_q;
`else
   assign flag_zero  = 1'b0;
   assign flag_carry = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec with a behavioural ALU,
// a reference register file, directed scenarios and random instructions.
module tb_alu_exec;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready;
   logic [3:0]    in_op;
   logic [2:0]    in_rd, in_rs1, in_rs2;
   logic          in_imm_sel;
   logic [W-1:0]  in_imm;
   logic [W-1:0]  alu_d1, alu_d2, alu_out;
   logic [3:0]    alu_op;
   logic          alu_iszero, alu_iscarry;
   logic          out_valid, out_zero, out_carry;
   logic [W-1:0]  out_data;
   logic [2:0]    out_rd;
   logic          wr_en;
   logic [2:0]    wr_addr;
   logic [W-1:0]  wr_data;
   logic [2:0]    dbg_addr;
   logic [W-1:0]  dbg_data;
   logic          flag_zero, flag_carry;

   alu_exec #(.WORD_SIZE(W), .REG_COUNT(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_imm_sel(in_imm_sel), .in_imm(in_imm),
      .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_op(alu_op),
      .alu_out(alu_out), .alu_iszero(alu_iszero), .alu_iscarry(alu_iscarry),
      .out_valid(out_valid), .out_data(out_data), .out_zero(out_zero),
      .out_carry(out_carry), .out_rd(out_rd),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .flag_zero(flag_zero), .flag_carry(flag_carry)
   );

   always #5 clk = ~clk;

   // Arithmetic meaning of each opcode: {carry, result}.
   function automatic logic [W:0] alu_fn(input logic [W-1:0] a, b,
                                         input logic [3:0] op);
      logic [W:0] r;
      r = '0;
      case (op)
         4'd0: r = {1'b0, a} + {1'b0, b};
         4'd1: begin r[W-1:0] = a - b; r[W] = (a < b); end
         4'd2: r[W-1:0] = a & b;
         4'd3: r[W-1:0] = a | b;
         4'd4: r[W-1:0] = a ^ b;
         4'd9: r[W-1:0] = a << b[5:0];
         default: r[W-1:0] = a;
      endcase
      return r;
   endfunction

   logic [W:0] alu_r;
   always_comb begin
      alu_r       = alu_fn(alu_d1, alu_d2, alu_op);
      alu_out     = alu_r[W-1:0];
      alu_iscarry = alu_r[W];
      alu_iszero  = (alu_r[W-1:0] == '0);
   end

   typedef struct {
      logic [W-1:0] data;
      logic         z;
      logic         c;
      logic [2:0]   rd;
      int           cyc;
   } exp_t;

   exp_t         sb[$];
   int           acc_cyc[$];
   logic [W-1:0] mreg [8];
   int           cyc = 0;
   int           passes = 0;
   int           total = 0;
   exp_t         me;
   logic [W:0]   mr;
   logic [W-1:0] ma, mb;

   task automatic check(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   initial forever @(posedge clk) cyc++;

   // Reference model and scoreboard, observed on the falling edge.
   initial begin
      for (int i = 0; i < 8; i++) mreg[i] = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
            for (int i = 0; i < 8; i++) mreg[i] = '0;
         end else begin
            if (in_valid && in_ready) begin
               ma = mreg[in_rs1];
               mb = in_imm_sel ? in_imm : mreg[in_rs2];
               mr = alu_fn(ma, mb, in_op);
               me.data = mr[W-1:0];
               me.c    = mr[W];
               me.z    = (mr[W-1:0] == '0);
               me.rd   = in_rd;
               me.cyc  = cyc + 2;
               sb.push_back(me);
               acc_cyc.push_back(cyc);
            end
            if (wr_en && wr_addr != 3'd0) mreg[wr_addr] = wr_data;
            if (out_valid) begin
               if (sb.size() == 0) begin
                  check("unexpected_out_valid", 1, 0);
               end else begin
                  me = sb.pop_front();
                  check("out_data", out_data, me.data);
                  check("out_zero", out_zero, me.z);
                  check("out_carry", out_carry, me.c);
                  check("out_rd", out_rd, me.rd);
                  check("latency", cyc, me.cyc);
                  if (me.rd != 3'd0) mreg[me.rd] = me.data;
               end
            end
         end
      end
   end

   task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   // Present an instruction; returns 1 ns after the accepting edge.
   task automatic issue(input logic [3:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic isel, input logic [W-1:0] imm);
      int n;
      in_valid   = 1'b1;
      in_op      = op;
      in_rd      = rd;
      in_rs1     = rs1;
      in_rs2     = rs2;
      in_imm_sel = isel;
      in_imm     = imm;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic dbg_chk(input string name, input logic [2:0] a,
                          input logic [W-1:0] exp);
      dbg_addr = a;
      #1;
      check(name, dbg_data, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin tick(1); n++; end
      check("drain", W'(sb.size()), 0);
      tick(1);
   endtask

   logic [3:0]   ops [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd15};
   logic         exp_flag;
   logic [W-1:0] rd_data, rimm;

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_imm_sel = 1'b0; in_imm = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_rd", out_rd, 0);
      check("rst_alu_d1", alu_d1, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_flags", {flag_zero, flag_carry}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);
      dbg_chk("rst_r1", 3'd1, 0);

      // ADD r3 = r1 + r2
      wr(3'd1, 6); wr(3'd2, 7);
      issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 0);
      check("exec_alu_d1", alu_d1, 6);
      check("exec_alu_d2", alu_d2, 7);
      tick(1);
      check("wb_alu_d1_hold", alu_d1, 6);
      dbg_chk("add_r3_before", 3'd3, 0);
      tick(1);
      dbg_chk("add_r3_after", 3'd3, 13);
      drain();

      // all-ones + imm 1 -> zero and carry
      wr(3'd1, {W{1'b1}});
      issue(4'd0, 3'd4, 3'd1, 3'd0, 1'b1, 1);
      tick(2);
`ifdef ALU_EXEC_FLAGS_EN
      exp_flag = 1'b1;
`else
      exp_flag = 1'b0;
`endif
      check("flag_zero", flag_zero, exp_flag);
      check("flag_carry", flag_carry, exp_flag);
      dbg_chk("ovf_r4", 3'd4, 0);
      drain();

      // SUB into r0
      wr(3'd1, 7); wr(3'd2, 6);
      issue(4'd1, 3'd0, 3'd1, 3'd2, 1'b0, 0);
      tick(2);
      dbg_chk("r0_const", 3'd0, 0);
      drain();

      // back-to-back with in_valid held high
      wr(3'd1, 6); wr(3'd2, 7);
      issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 0);
      issue(4'd9, 3'd5, 3'd3, 3'd0, 1'b1, 2);
      check("b2b_spacing",
            W'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), 3);
      drain();
      dbg_chk("shl_r5", 3'd5, 52);

      // preload collides with writeback to the same register
      wr(3'd1, 6); wr(3'd2, 7);
      issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 0);
      tick(1);
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 100;
      tick(1);
      wr_en = 1'b0;
      dbg_chk("collide_r3", 3'd3, 13);
      drain();

      // reset during EXEC aborts the instruction
      wr(3'd3, 9); wr(3'd1, 6); wr(3'd2, 7);
      issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 0);
      #1 rst = 1'b1;
      @(negedge clk);
      check("abort_out_valid", out_valid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("abort_in_ready", in_ready, 1);
      dbg_chk("abort_r3", 3'd3, 0);
      check("abort_alu_d1", alu_d1, 0);
      tick(4);

      // randomized traffic
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            rd_data = ($urandom_range(0, 1) == 1) ?
                      {$urandom, $urandom} : W'($urandom_range(0, 3));
            wr(3'($urandom_range(0, 7)), rd_data);
         end
         rimm = ($urandom_range(0, 1) == 1) ?
                {$urandom, $urandom} : W'($urandom_range(0, 5));
         issue(ops[$urandom_range(0, 6)], 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), rimm);
         tick($urandom_range(0, 3));
      end
      drain();
      for (int i = 0; i < 8; i++) dbg_chk("final_reg", 3'(i), mreg[i]);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 64, datapath width of operands, results and registers.
REQ-002 SHALL have parameter REG_COUNT, default 8, number of general registers (3-bit addresses).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports in_valid input 1 / in_ready output 1: instruction handshake.
REQ-006 SHALL have ports in_op input 4 (ALU opcode, forwarded unmodified), in_rd, in_rs1, in_rs2 input 3 (register addresses).
REQ-007 SHALL have ports in_imm_sel input 1 (1 = second operand from in_imm) and in_imm input WORD_SIZE.
REQ-008 SHALL have ports alu_d1, alu_d2 output WORD_SIZE and alu_op output 4: drive the external alu block.
REQ-009 SHALL have ports alu_out input WORD_SIZE, alu_iszero input 1, alu_iscarry input 1: results from the external alu.
REQ-010 SHALL have ports out_valid output 1, out_data output WORD_SIZE, out_zero output 1, out_carry output 1, out_rd output 3: result report.
REQ-011 SHALL have ports wr_en input 1, wr_addr input 3, wr_data input WORD_SIZE: register preload.
REQ-012 SHALL have ports dbg_addr input 3 and dbg_data output WORD_SIZE: combinational register read.
REQ-013 SHALL have ports flag_zero and flag_carry, output 1 each: sticky flags (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, WB; IDLE->EXEC on in_valid&&in_ready; EXEC->WB unconditionally; WB->IDLE unconditionally.
REQ-015 SHALL assert in_ready only in IDLE; in_valid outside IDLE has no effect.
REQ-016 SHALL, at the accepting edge, latch rs1 value, (in_imm_sel ? in_imm : rs2 value), in_op and in_rd.
REQ-017 SHALL drive alu_d1/alu_d2/alu_op from latched values during EXEC; these ports hold their last value in other states.
REQ-018 SHALL sample alu_out, alu_iszero, alu_iscarry at the edge ending EXEC.
REQ-019 SHALL, in WB only, assert out_valid for exactly one cycle with sampled out_data/out_zero/out_carry and out_rd; all hold their values otherwise.
REQ-020 SHALL write out_data to register out_rd at the edge ending WB; accept edge T gives out_valid in cycle T+2, register updated at T+3; throughput 1 instruction per 3 cycles.
REQ-021 SHALL treat register 0 as constant zero: reads return 0, all writes ignored.
REQ-022 SHALL apply wr_en writes in any state; same-edge collision with WB write to same address: WB value wins.
REQ-023 SHALL make dbg_data reflect register dbg_addr combinationally from current register contents.
REQ-024 SHALL read operands at the accept edge, so an instruction accepted in the IDLE following WB sees the written-back value.

Reset
REQ-025 SHALL, on rst, immediately force state IDLE, in_ready=1 after release, out_valid=0, out_data=0, out_zero=0, out_carry=0, out_rd=0, alu_d1=alu_d2=0, alu_op=0, flag_zero=flag_carry=0, all registers 0.
REQ-026 SHALL abort any in-flight instruction on rst mid-operation: no writeback, no out_valid.

Configuration
REQ-027 SHALL, with macro ALU_EXEC_FLAGS_EN defined, update flag_zero/flag_carry from out_zero/out_carry at the edge ending WB and hold them otherwise.
REQ-028 SHALL, without ALU_EXEC_FLAGS_EN, tie flag_zero and flag_carry to 0 and omit the flag registers.

Verification
REQ-029 Preload r1=6, r2=7; ADD (op 0000) rd=3, rs1=1, rs2=2 -> out_valid at T+2, out_data=13, out_zero=0, out_carry=0; dbg r3=13 at T+3.
REQ-030 Preload r1=64'hFFFFFFFFFFFFFFFF; op 0000, rs1=1, imm_sel=1, imm=1, rd=4 -> out_data=0, out_zero=1, out_carry=1; with ALU_EXEC_FLAGS_EN flag_zero=flag_carry=1 after WB, without both 0.
REQ-031 op 0001 rd=0, rs1=1 (7), rs2=2 (6) -> out_valid with out_data=1, out_rd=0; dbg r0 stays 0.
REQ-032 in_valid held high for two instructions: ADD r3=r1+r2 then SHL (op 1001) r5=r3 by imm 2 with r1=6, r2=7 -> second accepted 3 cycles after first, out_data=52.
REQ-033 rst pulsed during EXEC of ADD to rd=3 (r3 preloaded 9) -> no out_valid, r3=0 (reset), in_ready=1 first cycle after release.
REQ-034 wr_en to r3 (value 100) on same edge as WB to r3 (value 13) -> r3=13.
